csr_spmv_engine: RTL and testbench

//  Native-RTL, parametrised CSR sparse-matrix x dense-vector engine: y[r] = sum val[k]*x[col[k]], k in [rp[r],rp[r+1]).

---
 rtl/csr_spmv_pkg.sv | 26 ++
 rtl/csr_mac_sat.sv | 58 +++++
 rtl/csr_spmv_engine.sv | 220 ++++++++++++++++++++++
 tb/tb_csr_spmv_engine.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_spmv_pkg.sv
// Shared definitions for the CSR sparse-matrix x dense-vector engine:
// FSM state encoding and width helpers used by the engine and its MAC.
package csr_spmv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_ROWW = 3'd2,
    ST_VC   = 3'd3,
    ST_VCW  = 3'd4,
    ST_XW   = 3'd5,
    ST_WR   = 3'd6,
    ST_DONE = 3'd7
  } state_e;

  // Address width that never collapses to zero bits for tiny depths.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Accumulator wide enough that NNZ_MAX full-precision products cannot overflow.
  function automatic int acc_width(input int data_w, input int nnz_max);
    return 2 * data_w + $clog2(nnz_max + 1);
  endfunction

endpackage

// File: rtl/csr_mac_sat.sv
// Signed multiply-accumulate with clear, plus an output formatter that
// either saturates the accumulator to DATA_W or keeps its low bits.
module csr_mac_sat
  import csr_spmv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NNZ_MAX = 8,
  parameter int SAT     = 1
) (
  input  logic                     clk_i,
  input  logic                     srst_i,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic                     zero_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] y_o
);

  localparam int ACC_W = acc_width(DATA_W, NNZ_MAX);

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic [ACC_W-DATA_W:0]      top_bits;
  logic                       ovf;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i && !zero_i) begin
      acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  // Value fits in DATA_W only when every bit from the DATA_W sign bit upward agrees.
  assign top_bits = acc_q[ACC_W-1:DATA_W-1];
  assign ovf      = !((&top_bits) || !(|top_bits));

  always_comb begin
    y_o = acc_q[DATA_W-1:0];
    if (SAT != 0 && ovf) begin
      y_o = acc_q[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/csr_spmv_engine.sv
// CSR SpMV engine: walks row pointers, fetches value/column/x through
// 1-cycle block-RAM ports, accumulates each row and writes y under ap_* control.
module csr_spmv_engine
  import csr_spmv_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 32,
  parameter int N_ROWS  = 4,
  parameter int N_COLS  = 4,
  parameter int NNZ_MAX = 8,
  parameter int SAT     = 1
) (
  input  logic                                  ap_clk,
  input  logic                                  ap_rst,
  input  logic                                  ap_start,
  output logic                                  ap_done,
  output logic                                  ap_idle,
  output logic                                  ap_ready,
  output logic [clog2_min1(N_ROWS+1)-1:0]       row_index_address0,
  output logic                                  row_index_ce0,
  input  logic [IDX_W-1:0]                      row_index_q0,
  output logic [clog2_min1(N_ROWS+1)-1:0]       row_index_address1,
  output logic                                  row_index_ce1,
  input  logic [IDX_W-1:0]                      row_index_q1,
  output logic [clog2_min1(NNZ_MAX)-1:0]        value_r_address0,
  output logic                                  value_r_ce0,
  input  logic [DATA_W-1:0]                     value_r_q0,
  output logic [clog2_min1(NNZ_MAX)-1:0]        col_index_address0,
  output logic                                  col_index_ce0,
  input  logic [IDX_W-1:0]                      col_index_q0,
  output logic [clog2_min1(N_COLS)-1:0]         x_address0,
  output logic                                  x_ce0,
  input  logic [DATA_W-1:0]                     x_q0,
  output logic [clog2_min1(N_ROWS)-1:0]         y_address0,
  output logic                                  y_ce0,
  output logic                                  y_we0,
  output logic [DATA_W-1:0]                     y_d0,
  output logic                                  err_col,
  output logic                                  err_ptr
);

  localparam int RAW = clog2_min1(N_ROWS + 1);
  localparam int KAW = clog2_min1(NNZ_MAX);
  localparam int KW  = clog2_min1(NNZ_MAX + 1);
  localparam int CAW = clog2_min1(N_COLS);
  localparam int YAW = clog2_min1(N_ROWS);

  state_e                    state_q, state_d;
  logic [RAW-1:0]            r_q, r_d;
  logic [KW-1:0]             k_q, k_d, kend_q, kend_d;
  logic signed [DATA_W-1:0]  val_q, val_d;
  logic                      col_bad_q, col_bad_d;
  logic                      err_col_q, err_col_d;
  logic                      err_ptr_q, err_ptr_d;

  logic                      row_ce_q, row_ce_d;
  logic [RAW-1:0]            row_addr0_q, row_addr0_d;
  logic [RAW-1:0]            row_addr1_q, row_addr1_d;
  logic                      kv_ce_q, kv_ce_d;
  logic [KAW-1:0]            kv_addr_q, kv_addr_d;
  logic                      y_wr_q, y_wr_d;
  logic [YAW-1:0]            y_addr_q, y_addr_d;
  logic                      done_q, done_d;
  logic                      idle_q, idle_d;

  logic                      ptr_bad;
  logic                      row_empty;
  logic                      col_ok;
  logic                      last_row;
  logic [KW-1:0]             k_inc;

  assign ptr_bad   = (row_index_q1 < row_index_q0) || (row_index_q1 > IDX_W'(NNZ_MAX));
  assign row_empty = ptr_bad || (row_index_q1 == row_index_q0);
  assign col_ok    = col_index_q0 < IDX_W'(N_COLS);
  assign last_row  = r_q == RAW'(N_ROWS - 1);
  assign k_inc     = k_q + KW'(1);

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= ST_IDLE;
      r_q         <= '0;
      k_q         <= '0;
      kend_q      <= '0;
      val_q       <= '0;
      col_bad_q   <= 1'b0;
      err_col_q   <= 1'b0;
      err_ptr_q   <= 1'b0;
      row_ce_q    <= 1'b0;
      row_addr0_q <= '0;
      row_addr1_q <= '0;
      kv_ce_q     <= 1'b0;
      kv_addr_q   <= '0;
      y_wr_q      <= 1'b0;
      y_addr_q    <= '0;
      done_q      <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      k_q         <= k_d;
      kend_q      <= kend_d;
      val_q       <= val_d;
      col_bad_q   <= col_bad_d;
      err_col_q   <= err_col_d;
      err_ptr_q   <= err_ptr_d;
      row_ce_q    <= row_ce_d;
      row_addr0_q <= row_addr0_d;
      row_addr1_q <= row_addr1_d;
      kv_ce_q     <= kv_ce_d;
      kv_addr_q   <= kv_addr_d;
      y_wr_q      <= y_wr_d;
      y_addr_q    <= y_addr_d;
      done_q      <= done_d;
      idle_q      <= idle_d;
    end
  end

  // A malformed pointer pair is flagged and the row degrades to an empty row.
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    k_d       = k_q;
    kend_d    = kend_q;
    val_d     = val_q;
    col_bad_d = col_bad_q;
    err_col_d = err_col_q;
    err_ptr_d = err_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d   = ST_ROW;
          r_d       = '0;
          err_col_d = 1'b0;
          err_ptr_d = 1'b0;
        end
      end
      ST_ROW: state_d = ST_ROWW;
      ST_ROWW: begin
        if (ptr_bad) begin
          err_ptr_d = 1'b1;
          k_d       = '0;
          kend_d    = '0;
        end else begin
          k_d    = row_index_q0[KW-1:0];
          kend_d = row_index_q1[KW-1:0];
        end
        state_d = row_empty ? ST_WR : ST_VC;
      end
      ST_VC: state_d = ST_VCW;
      ST_VCW: begin
        val_d     = value_r_q0;
        col_bad_d = !col_ok;
        if (!col_ok) begin
          err_col_d = 1'b1;
        end
        state_d = ST_XW;
      end
      ST_XW: begin
        k_d     = k_inc;
        state_d = (k_inc == kend_q) ? ST_WR : ST_VC;
      end
      ST_WR: begin
        r_d     = r_q + RAW'(1);
        state_d = last_row ? ST_DONE : ST_ROW;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are computed from the upcoming state so they leave a flop aligned with it.
  always_comb begin
    row_ce_d    = (state_d == ST_ROW);
    row_addr0_d = (state_d == ST_ROW) ? r_d : row_addr0_q;
    row_addr1_d = (state_d == ST_ROW) ? r_d + RAW'(1) : row_addr1_q;
    kv_ce_d     = (state_d == ST_VC);
    kv_addr_d   = (state_d == ST_VC) ? k_d[KAW-1:0] : kv_addr_q;
    y_wr_d      = (state_d == ST_WR);
    y_addr_d    = (state_d == ST_WR) ? r_d[YAW-1:0] : y_addr_q;
    done_d      = (state_d == ST_DONE);
    idle_d      = (state_d == ST_IDLE);
  end

  csr_mac_sat #(
    .DATA_W (DATA_W),
    .NNZ_MAX(NNZ_MAX),
    .SAT    (SAT)
  ) u_mac (
    .clk_i (ap_clk),
    .srst_i(ap_rst),
    .clr_i ((state_q == ST_WR) || (state_q == ST_IDLE && ap_start)),
    .en_i  (state_q == ST_XW),
    .zero_i(col_bad_q),
    .a_i   (val_q),
    .b_i   (x_q0),
    .y_o   (y_d0)
  );

  // The x fetch is issued straight off the column RAM output to keep 3 cycles per nonzero.
  assign x_ce0      = (state_q == ST_VCW) && col_ok;
  assign x_address0 = (state_q == ST_VCW) ? col_index_q0[CAW-1:0] : '0;

  assign ap_done            = done_q;
  assign ap_ready           = done_q;
  assign ap_idle            = idle_q;
  assign row_index_ce0      = row_ce_q;
  assign row_index_ce1      = row_ce_q;
  assign row_index_address0 = row_addr0_q;
  assign row_index_address1 = row_addr1_q;
  assign value_r_ce0        = kv_ce_q;
  assign col_index_ce0      = kv_ce_q;
  assign value_r_address0   = kv_addr_q;
  assign col_index_address0 = kv_addr_q;
  assign y_ce0              = y_wr_q;
  assign y_we0              = y_wr_q;
  assign y_address0         = y_addr_q;
  assign err_col            = err_col_q;
  assign err_ptr            = err_ptr_q;

endmodule

// File: tb/tb_csr_spmv_engine.sv
// Randomized bench for csr_spmv_engine: a saturating and a wrapping instance share
// the same matrix RAMs and are checked against a plain-arithmetic CSR model.
module tb_csr_spmv_engine;

  localparam int NR = 4;
  localparam int NC = 4;
  localparam int NZ = 8;

  logic ap_clk;
  logic ap_rst;
  logic ap_start;

  logic [31:0] rp_mem  [8];
  logic [31:0] val_mem [8];
  logic [31:0] col_mem [8];
  logic [31:0] x_mem   [4];

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_ys [NR];
  logic [31:0] exp_yw [NR];
  int          exp_lat;
  int          exp_xce;
  logic        exp_ec;
  logic        exp_ep;

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Instance 0 saturates, instance 1 wraps.
  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic        ap_done, ap_idle, ap_ready;
    logic [2:0]  ra0, ra1, va, ca;
    logic        rce0, rce1, vce, cce, xce, yce, ywe;
    logic [31:0] rq0, rq1, vq, cq, xq, yd;
    logic [1:0]  xa, ya;
    logic        err_col, err_ptr;
    logic [31:0] y_mem [NR];
    int          y_wr [NR] = '{0, 0, 0, 0};
    int          x_cnt = 0;

    csr_spmv_engine #(
      .DATA_W(32), .IDX_W(32), .N_ROWS(NR), .N_COLS(NC), .NNZ_MAX(NZ),
      .SAT(gi == 0 ? 1 : 0)
    ) u_dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
      .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .row_index_address0(ra0), .row_index_ce0(rce0), .row_index_q0(rq0),
      .row_index_address1(ra1), .row_index_ce1(rce1), .row_index_q1(rq1),
      .value_r_address0(va), .value_r_ce0(vce), .value_r_q0(vq),
      .col_index_address0(ca), .col_index_ce0(cce), .col_index_q0(cq),
      .x_address0(xa), .x_ce0(xce), .x_q0(xq),
      .y_address0(ya), .y_ce0(yce), .y_we0(ywe), .y_d0(yd),
      .err_col(err_col), .err_ptr(err_ptr)
    );

    always @(posedge ap_clk) begin
      if (rce0) rq0 <= rp_mem[ra0];
      if (rce1) rq1 <= rp_mem[ra1];
      if (vce)  vq  <= val_mem[va];
      if (cce)  cq  <= col_mem[ca];
      if (xce) begin
        xq    <= x_mem[xa];
        x_cnt <= x_cnt + 1;
      end
      if (yce && ywe) begin
        y_mem[ya] <= yd;
        y_wr[ya]  <= y_wr[ya] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: evaluate y[r] = sum val[k]*x[col[k]] directly from the CSR arrays.
  task automatic model();
    longint acc;
    int lo, hi, nnz;
    exp_lat = 1;
    exp_xce = 0;
    exp_ec  = 1'b0;
    exp_ep  = 1'b0;
    for (int r = 0; r < NR; r++) begin
      lo  = int'(rp_mem[r]);
      hi  = int'(rp_mem[r+1]);
      acc = 0;
      nnz = 0;
      if (rp_mem[r+1] < rp_mem[r] || rp_mem[r+1] > NZ) begin
        exp_ep = 1'b1;
      end else begin
        nnz = hi - lo;
        for (int k = lo; k < hi; k++) begin
          if (col_mem[k] >= NC) begin
            exp_ec = 1'b1;
          end else begin
            exp_xce++;
            acc += longint'(int'(val_mem[k])) * longint'(int'(x_mem[col_mem[k][1:0]]));
          end
        end
      end
      exp_lat += 3 + 3 * nnz;
      exp_yw[r] = acc[31:0];
      if (acc > 64'sd2147483647)       exp_ys[r] = 32'h7FFF_FFFF;
      else if (acc < -64'sd2147483648) exp_ys[r] = 32'h8000_0000;
      else                             exp_ys[r] = acc[31:0];
    end
  endtask

  task automatic load_example();
    for (int i = 0; i < 8; i++) begin
      rp_mem[i] = 0; val_mem[i] = 0; col_mem[i] = 0;
    end
    rp_mem[0] = 0; rp_mem[1] = 2; rp_mem[2] = 3; rp_mem[3] = 3; rp_mem[4] = 5;
    val_mem[0] = 1; val_mem[1] = 2; val_mem[2] = 3; val_mem[3] = 4; val_mem[4] = 5;
    col_mem[0] = 0; col_mem[1] = 3; col_mem[2] = 1; col_mem[3] = 0; col_mem[4] = 2;
    x_mem[0] = 1; x_mem[1] = 2; x_mem[2] = 3; x_mem[3] = 4;
  endtask

  function automatic logic [31:0] rand_val();
    int v;
    if ($urandom_range(0, 2) == 0) v = int'($urandom_range(0, 20)) - 10;
    else                           v = int'($urandom_range(0, 32'h1FFF_FFFF)) - 32'sh1000_0000;
    return v;
  endfunction

  task automatic check_results(input string tag, input int ws0[NR], input int ws1[NR],
                               input int xs0, input int xs1, input int passes);
    for (int r = 0; r < NR; r++) begin
      chk({tag, ".y_sat"},  g_dut[0].y_mem[r], exp_ys[r]);
      chk({tag, ".y_wrap"}, g_dut[1].y_mem[r], exp_yw[r]);
      chk({tag, ".wr0"}, g_dut[0].y_wr[r] - ws0[r], passes);
      chk({tag, ".wr1"}, g_dut[1].y_wr[r] - ws1[r], passes);
    end
    chk({tag, ".err_col"}, g_dut[0].err_col, exp_ec);
    chk({tag, ".err_ptr"}, g_dut[0].err_ptr, exp_ep);
    chk({tag, ".err_col1"}, g_dut[1].err_col, exp_ec);
    chk({tag, ".err_ptr1"}, g_dut[1].err_ptr, exp_ep);
    chk({tag, ".x_ce"},  g_dut[0].x_cnt - xs0, exp_xce * passes);
    chk({tag, ".x_ce1"}, g_dut[1].x_cnt - xs1, exp_xce * passes);
  endtask

  task automatic run_check(input string tag);
    int  n = 0;
    bit  seen = 0;
    int  ws0 [NR];
    int  ws1 [NR];
    int  xs0, xs1;
    model();
    @(negedge ap_clk);
    for (int r = 0; r < NR; r++) begin
      ws0[r] = g_dut[0].y_wr[r];
      ws1[r] = g_dut[1].y_wr[r];
    end
    xs0 = g_dut[0].x_cnt;
    xs1 = g_dut[1].x_cnt;
    ap_start = 1'b1;
    while (!seen && n < 1000) begin
      @(posedge ap_clk);
      n++;
      @(negedge ap_clk);
      ap_start = 1'b0;
      if (g_dut[0].ap_done) seen = 1;
    end
    chk({tag, ".lat"}, n, exp_lat);
    chk({tag, ".ready"}, g_dut[0].ap_ready, 1'b1);
    chk({tag, ".done1"}, g_dut[1].ap_done, 1'b1);
    check_results(tag, ws0, ws1, xs0, xs1, 1);
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk({tag, ".done_drop"}, g_dut[0].ap_done, 1'b0);
    chk({tag, ".idle"}, g_dut[0].ap_idle, 1'b1);
    $display("run %s lat=%0d y_sat=%h,%h,%h,%h ec=%0b ep=%0b", tag, n,
             g_dut[0].y_mem[0], g_dut[0].y_mem[1], g_dut[0].y_mem[2], g_dut[0].y_mem[3],
             g_dut[0].err_col, g_dut[0].err_ptr);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ws0 [NR];
    int ws1 [NR];
    int xs0, xs1, n, passes, tot, cnt;

    ap_rst   = 1'b1;
    ap_start = 1'b0;
    load_example();
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    chk("rst.idle", g_dut[0].ap_idle, 1'b1);
    chk("rst.done", g_dut[0].ap_done, 1'b0);
    chk("rst.ready", g_dut[0].ap_ready, 1'b0);
    chk("rst.row_ce", g_dut[0].rce0, 1'b0);
    chk("rst.val_ce", g_dut[0].vce, 1'b0);
    chk("rst.y_we", g_dut[0].ywe, 1'b0);
    chk("rst.x_ce", g_dut[0].xce, 1'b0);
    chk("rst.err_col", g_dut[0].err_col, 1'b0);
    chk("rst.err_ptr", g_dut[0].err_ptr, 1'b0);
    chk("rst.row_addr", g_dut[0].ra0, 3'd0);
    chk("rst.y_d", g_dut[0].yd, 32'd0);
    ap_rst = 1'b0;

    run_check("example");
    chk("example.lat_const", exp_lat, 28);

    load_example();
    rp_mem[1] = 1; rp_mem[2] = 1; rp_mem[3] = 1; rp_mem[4] = 1;
    val_mem[0] = 32'h7FFF_FFFF; col_mem[0] = 0; x_mem[0] = 2;
    run_check("sat");

    load_example();
    col_mem[1] = 7; val_mem[1] = 5;
    run_check("badcol");

    load_example();
    rp_mem[1] = 3; rp_mem[2] = 1; rp_mem[3] = 3; rp_mem[4] = 5;
    run_check("badptr");

    // Reset while row 2 is being fetched; nothing further may be written.
    load_example();
    @(negedge ap_clk);
    for (int r = 0; r < NR; r++) ws0[r] = g_dut[0].y_wr[r];
    ap_start = 1'b1;
    n = 0;
    while (g_dut[0].y_wr[1] == ws0[1] && n < 200) begin
      @(posedge ap_clk);
      n++;
      @(negedge ap_clk);
      ap_start = 1'b0;
    end
    chk("midrst.reach_r2", g_dut[0].y_wr[1] - ws0[1], 1);
    ap_rst = 1'b1;
    @(posedge ap_clk);
    @(negedge ap_clk);
    chk("midrst.idle", g_dut[0].ap_idle, 1'b1);
    chk("midrst.row_ce", g_dut[0].rce0 | g_dut[0].rce1, 1'b0);
    chk("midrst.kv_ce", g_dut[0].vce | g_dut[0].cce, 1'b0);
    chk("midrst.x_ce", g_dut[0].xce, 1'b0);
    chk("midrst.y", g_dut[0].yce | g_dut[0].ywe, 1'b0);
    ap_rst = 1'b0;
    chk("midrst.no_wr2", g_dut[0].y_wr[2] - ws0[2], 0);
    chk("midrst.no_wr3", g_dut[0].y_wr[3] - ws0[3], 0);
    run_check("rerun");

    // Start held high: back-to-back passes with one idle cycle between them.
    load_example();
    model();
    @(negedge ap_clk);
    for (int r = 0; r < NR; r++) begin
      ws0[r] = g_dut[0].y_wr[r];
      ws1[r] = g_dut[1].y_wr[r];
    end
    xs0 = g_dut[0].x_cnt;
    xs1 = g_dut[1].x_cnt;
    ap_start = 1'b1;
    n = 0;
    passes = 0;
    while (passes < 3 && n < 400) begin
      @(posedge ap_clk);
      n++;
      @(negedge ap_clk);
      if (g_dut[0].ap_done) begin
        passes++;
        chk("hold.done_cyc", n, exp_lat + (passes - 1) * (exp_lat + 1));
        check_results("hold", ws0, ws1, xs0, xs1, passes);
        $display("run hold pass=%0d done_cycle=%0d", passes, n);
        if (passes == 3) ap_start = 1'b0;
      end
    end
    chk("hold.passes", passes, 3);
    ap_start = 1'b0;
    repeat (2) begin
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    chk("hold.stays_idle", g_dut[0].ap_idle, 1'b1);

    for (int it = 0; it < 20; it++) begin
      tot = 0;
      rp_mem[0] = 0;
      for (int r = 0; r < NR; r++) begin
        cnt = int'($urandom_range(0, 3));
        if (tot + cnt > NZ) cnt = NZ - tot;
        tot += cnt;
        rp_mem[r+1] = tot;
      end
      if ($urandom_range(0, 4) == 0) rp_mem[$urandom_range(1, 4)] = $urandom_range(0, 10);
      for (int k = 0; k < NZ; k++) begin
        val_mem[k] = rand_val();
        col_mem[k] = $urandom_range(0, 4);
        if ($urandom_range(0, 15) == 0) col_mem[k] = 32'hFFFF_FFF0;
      end
      for (int c = 0; c < NC; c++) x_mem[c] = rand_val();
      run_check($sformatf("rand%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
